// File: rtl/ctrl_sequencer.sv
// Multi-cycle CPU control sequencer: fetch/decode/execute/mem/writeback FSM that
// drives the pipeline-latch write enables, with wait states, halt and a retire counter.
module ctrl_sequencer #(
   parameter int FETCH_WAIT = 1,
   parameter int MEM_WAIT   = 1,
   parameter int WAIT_W     = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mem_ready,
   input  logic             dec_mem_access,
   input  logic             dec_reg_write,
   input  logic             halt_req,
   output logic             pc_wren,
   output logic             ram_addr_src,
   output logic             fd_wren,
   output logic             de_wren,
   output logic             em_wren,
   output logic             mw_wren,
   output logic             mw_mem_wren,
   output logic             reg_wren,
   output logic             refresh_n,
   output logic [3:0]       state,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_INIT       = 4'd0,
      S_FETCH      = 4'd1,
      S_FETCH_WAIT = 4'd2,
      S_DECODE     = 4'd3,
      S_EXECUTE    = 4'd4,
      S_MEM        = 4'd5,
      S_MEM_WAIT   = 4'd6,
      S_WB         = 4'd7,
      S_HALT       = 4'd8
   } state_t;

   localparam logic [WAIT_W-1:0] FW_LAST = WAIT_W'(FETCH_WAIT - 1);
   localparam logic [WAIT_W-1:0] MW_LAST = WAIT_W'(MEM_WAIT - 1);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              mem_q, mem_d;
   logic              wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [WAIT_W-1:0] wait_inc;
   logic              fetch_done;
   logic              mem_done;

   // Wait counter saturates so an arbitrarily long mem_ready stall never wraps it.
   assign wait_inc   = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
   assign fetch_done = (wait_cnt_q >= FW_LAST) && mem_ready;
   assign mem_done   = !mem_q || ((wait_cnt_q >= MW_LAST) && mem_ready);

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      mem_d        = mem_q;
      wr_d         = wr_q;
      cnt_d        = cnt_q;
      pc_wren      = 1'b0;
      ram_addr_src = 1'b0;
      fd_wren      = 1'b0;
      de_wren      = 1'b0;
      em_wren      = 1'b0;
      mw_wren      = 1'b0;
      mw_mem_wren  = 1'b0;
      reg_wren     = 1'b0;
      refresh_n    = 1'b1;
      halted       = 1'b0;
      case (state_q)
         S_INIT: begin
            refresh_n = 1'b0;
            state_d   = S_FETCH;
         end
         S_FETCH: begin
            wait_cnt_d = '0;
            state_d    = S_FETCH_WAIT;
         end
         S_FETCH_WAIT: begin
            wait_cnt_d = wait_inc;
            if (fetch_done) begin
               fd_wren = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            de_wren = 1'b1;
            mem_d   = dec_mem_access;
            wr_d    = dec_reg_write;
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            em_wren = 1'b1;
            state_d = S_MEM;
         end
         S_MEM: begin
            pc_wren      = 1'b1;
            ram_addr_src = 1'b1;
            mw_mem_wren  = mem_q;
            wait_cnt_d   = '0;
            state_d      = S_MEM_WAIT;
         end
         S_MEM_WAIT: begin
            // Non-memory instructions pass straight through without waiting on mem_ready.
            wait_cnt_d = wait_inc;
            if (mem_done) begin
               mw_wren = 1'b1;
               state_d = S_WB;
            end
         end
         S_WB: begin
            reg_wren  = wr_q;
            refresh_n = 1'b0;
            cnt_d     = cnt_q + 1'b1;
            state_d   = halt_req ? S_HALT : S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            if (!halt_req) state_d = S_FETCH;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_INIT;
         wait_cnt_q <= '0;
         mem_q      <= 1'b0;
         wr_q       <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         mem_q      <= mem_d;
         wr_q       <= wr_d;
         cnt_q      <= cnt_d;
      end
   end

   assign state       = state_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two instances (default and FETCH_WAIT=2/MEM_WAIT=3/CNT_W=2)
// checked cycle by cycle against an instruction-level schedule built from the phase rules.
module tb_ctrl_sequencer;

   localparam logic [9:0] C_PC   = 10'h200;
   localparam logic [9:0] C_RAS  = 10'h100;
   localparam logic [9:0] C_FD   = 10'h080;
   localparam logic [9:0] C_DE   = 10'h040;
   localparam logic [9:0] C_EM   = 10'h020;
   localparam logic [9:0] C_MW   = 10'h010;
   localparam logic [9:0] C_MWM  = 10'h008;
   localparam logic [9:0] C_REG  = 10'h004;
   localparam logic [9:0] C_REF  = 10'h002;
   localparam logic [9:0] C_HALT = 10'h001;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst [2];
   logic mr  [2];
   logic ma  [2];
   logic rw  [2];
   logic hr  [2];

   int errors = 0;
   int checks = 0;
   int exp_cnt [2];

   logic       a_pc, a_ras, a_fd, a_de, a_em, a_mw, a_mwm, a_reg, a_ref, a_halt;
   logic [3:0] a_state;
   logic [31:0] a_cnt;
   logic       b_pc, b_ras, b_fd, b_de, b_em, b_mw, b_mwm, b_reg, b_ref, b_halt;
   logic [3:0] b_state;
   logic [1:0] b_cnt;

   wire [3:0]  st_obs  [2];
   wire [9:0]  ctl_obs [2];
   wire [31:0] cnt_obs [2];

   assign st_obs[0]  = a_state;
   assign st_obs[1]  = b_state;
   assign ctl_obs[0] = {a_pc, a_ras, a_fd, a_de, a_em, a_mw, a_mwm, a_reg, a_ref, a_halt};
   assign ctl_obs[1] = {b_pc, b_ras, b_fd, b_de, b_em, b_mw, b_mwm, b_reg, b_ref, b_halt};
   assign cnt_obs[0] = a_cnt;
   assign cnt_obs[1] = {30'd0, b_cnt};

   ctrl_sequencer dut_a (
      .clk(clk), .reset(rst[0]), .mem_ready(mr[0]), .dec_mem_access(ma[0]),
      .dec_reg_write(rw[0]), .halt_req(hr[0]),
      .pc_wren(a_pc), .ram_addr_src(a_ras), .fd_wren(a_fd), .de_wren(a_de),
      .em_wren(a_em), .mw_wren(a_mw), .mw_mem_wren(a_mwm), .reg_wren(a_reg),
      .refresh_n(a_ref), .state(a_state), .halted(a_halt), .instr_count(a_cnt)
   );

   ctrl_sequencer #(.FETCH_WAIT(2), .MEM_WAIT(3), .WAIT_W(4), .CNT_W(2)) dut_b (
      .clk(clk), .reset(rst[1]), .mem_ready(mr[1]), .dec_mem_access(ma[1]),
      .dec_reg_write(rw[1]), .halt_req(hr[1]),
      .pc_wren(b_pc), .ram_addr_src(b_ras), .fd_wren(b_fd), .de_wren(b_de),
      .em_wren(b_em), .mw_wren(b_mw), .mw_mem_wren(b_mwm), .reg_wren(b_reg),
      .refresh_n(b_ref), .state(b_state), .halted(b_halt), .instr_count(b_cnt)
   );

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive inputs, compare on the falling edge, advance past the next rising edge.
   task automatic step(input int d, input logic r, input logic m, input logic a,
                       input logic w, input logic h, input logic [3:0] es,
                       input logic [9:0] ec, input int ecnt, input string tag);
      logic [31:0] ecm;
      rst[d] = r; mr[d] = m; ma[d] = a; rw[d] = w; hr[d] = h;
      @(negedge clk);
      ecm = (d == 1) ? (32'(ecnt) & 32'h3) : 32'(ecnt);
      checks++;
      assert (st_obs[d] === es) else begin
         errors++;
         $error("FAIL %s dut%0d state: got %0d expected %0d", tag, d, st_obs[d], es);
      end
      checks++;
      assert (ctl_obs[d] === ec) else begin
         errors++;
         $error("FAIL %s dut%0d ctrl: got %b expected %b", tag, d, ctl_obs[d], ec);
      end
      checks++;
      assert (cnt_obs[d] === ecm) else begin
         errors++;
         $error("FAIL %s dut%0d count: got %0d expected %0d", tag, d, cnt_obs[d], ecm);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      exp_cnt[d] = 0;
      step(d, 1'b0, rb(), rb(), rb(), rb(), 4'd0, 10'd0, 0, "reset_init");
   endtask

   // Expands one instruction into its per-cycle expectations from the phase rules.
   task automatic run_instr(input int d, input int fw, input int mw, input logic ima,
                            input logic irw, input logic hlt, input int fstall,
                            input int mstall, input int hcyc, input logic abort);
      int c;
      c = exp_cnt[d];
      step(d, 0, rb(), rb(), rb(), rb(), 4'd1, C_REF, c, "fetch");
      for (int i = 0; i < fw - 1; i++)
         step(d, 0, rb(), rb(), rb(), rb(), 4'd2, C_REF, c, "fwait_min");
      for (int i = 0; i < fstall; i++)
         step(d, 0, 1'b0, rb(), rb(), rb(), 4'd2, C_REF, c, "fwait_stall");
      step(d, 0, 1'b1, rb(), rb(), rb(), 4'd2, C_REF | C_FD, c, "fwait_exit");
      step(d, 0, rb(), ima, irw, rb(), 4'd3, C_REF | C_DE, c, "decode");
      step(d, 0, rb(), rb(), rb(), rb(), 4'd4, C_REF | C_EM, c, "execute");
      step(d, 0, rb(), rb(), rb(), rb(), 4'd5, C_REF | C_PC | C_RAS | (ima ? C_MWM : 10'd0),
           c, "mem");
      if (!ima) begin
         step(d, 0, rb(), rb(), rb(), rb(), 4'd6, C_REF | C_MW, c, "mwait_bypass");
      end else begin
         for (int i = 0; i < mw - 1; i++)
            step(d, 0, rb(), rb(), rb(), rb(), 4'd6, C_REF, c, "mwait_min");
         if (abort) begin
            step(d, 1, 1'b0, rb(), rb(), rb(), 4'd6, C_REF, c, "mwait_abort");
            exp_cnt[d] = 0;
            step(d, 0, rb(), rb(), rb(), rb(), 4'd0, 10'd0, 0, "init_after_reset");
            return;
         end
         for (int i = 0; i < mstall; i++)
            step(d, 0, 1'b0, rb(), rb(), rb(), 4'd6, C_REF, c, "mwait_stall");
         step(d, 0, 1'b1, rb(), rb(), rb(), 4'd6, C_REF | C_MW, c, "mwait_exit");
      end
      step(d, 0, rb(), rb(), rb(), hlt, 4'd7, irw ? C_REG : 10'd0, c, "wb");
      c = c + 1;
      exp_cnt[d] = c;
      if (hlt) begin
         for (int i = 0; i < hcyc; i++)
            step(d, 0, rb(), rb(), rb(), 1'b1, 4'd8, C_REF | C_HALT, c, "halt");
         step(d, 0, rb(), rb(), rb(), 1'b0, 4'd8, C_REF | C_HALT, c, "halt_exit");
      end
   endtask

   initial begin
      rst = '{1'b1, 1'b1};
      mr  = '{1'b0, 1'b0};
      ma  = '{1'b0, 1'b0};
      rw  = '{1'b0, 1'b0};
      hr  = '{1'b0, 1'b0};
      exp_cnt = '{0, 0};

      // Default instance: basic flow, no reg write, random mix, halt.
      do_reset(0);
      run_instr(0, 1, 1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      run_instr(0, 1, 1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
      for (int k = 0; k < 8; k++)
         run_instr(0, 1, 1, rb(), rb(), 1'($urandom_range(0, 3) == 0),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      run_instr(0, 1, 1, 1'b1, 1'b1, 1'b1, 0, 0, 3, 1'b0);
      run_instr(0, 1, 1, 1'b0, 1'b1, 1'b0, 2, 0, 0, 1'b0);
      rst[0] = 1'b1;

      // Deeper waits and a 2-bit counter.
      do_reset(1);
      run_instr(1, 2, 3, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      run_instr(1, 2, 3, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0);
      run_instr(1, 2, 3, 1'b1, 1'b0, 1'b0, 5, 2, 0, 1'b0);
      for (int k = 0; k < 6; k++)
         run_instr(1, 2, 3, rb(), rb(), 1'($urandom_range(0, 3) == 0),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);
      run_instr(1, 2, 3, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b1);
      for (int k = 0; k < 6; k++)
         run_instr(1, 2, 3, rb(), rb(), 1'b0, $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
